ex_hazard_ctrl: RTL and testbench

//   Pipeline hazard controller for the EX-stage ALU operand path. Generates the
//   per-operand forwarding selects (EX/MEM/WB -> rD1/rD2 before the A/B muxes),

---
 rtl/ex_hazard_ctrl_if.sv | 23 ++
 rtl/ex_hazard_ctrl.sv | 97 +++++++++
 tb/tb_ex_hazard_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ex_hazard_ctrl_if.sv
// ex_hazard_ctrl_if: pipeline-side operand, hazard and mul/div handshake signals of the EX hazard controller
interface ex_hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use_rs1, id_use_rs2, ex_we, ex_is_load, mem_we, wb_we;
  logic ex_md_op, ex_redirect, md_done;
  logic [1:0] fwd_a, fwd_b;
  logic stall_pc, stall_if_id, stall_id_ex;
  logic flush_if_id, flush_id_ex, flush_ex_mem;
  logic md_start, md_timeout;
  logic [CNT_W-1:0] stall_cnt;
  modport master (
    output id_rs1, id_rs2, ex_rd, mem_rd, wb_rd, id_use_rs1, id_use_rs2,
           ex_we, ex_is_load, mem_we, wb_we, ex_md_op, ex_redirect, md_done,
    input  fwd_a, fwd_b, stall_pc, stall_if_id, stall_id_ex, flush_if_id,
           flush_id_ex, flush_ex_mem, md_start, md_timeout, stall_cnt
  );
  modport slave (
    input  id_rs1, id_rs2, ex_rd, mem_rd, wb_rd, id_use_rs1, id_use_rs2,
           ex_we, ex_is_load, mem_we, wb_we, ex_md_op, ex_redirect, md_done,
    output fwd_a, fwd_b, stall_pc, stall_if_id, stall_id_ex, flush_if_id,
           flush_id_ex, flush_ex_mem, md_start, md_timeout, stall_cnt
  );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: operand forwarding selects, load-use bubbles, redirect flushes and mul/div stall handshake
module ex_hazard_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W = 32
) (
  input logic cpu_clk,
  input logic cpu_rst,
  ex_hazard_ctrl_if.slave hz
);
  localparam int WW = $clog2(MD_TIMEOUT);
  typedef enum logic {S_RUN, S_MD_WAIT} state_t;
  state_t state, state_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic to_q, to_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic va, vb, ex_a, ex_b, lu_a, lu_b;
  logic [1:0] fa, fb;
  logic st_pc, st_if_id, st_id_ex, fl_if_id, fl_id_ex, fl_ex_mem, start;
  always_comb begin
    va = hz.id_use_rs1 & (hz.id_rs1 != 5'd0);
    vb = hz.id_use_rs2 & (hz.id_rs2 != 5'd0);
    ex_a = va & hz.ex_we & (hz.id_rs1 == hz.ex_rd);
    ex_b = vb & hz.ex_we & (hz.id_rs2 == hz.ex_rd);
    lu_a = ex_a & hz.ex_is_load;
    lu_b = ex_b & hz.ex_is_load;
    // a load in EX has no data yet: read RF now, the stall lets MEM forward next cycle
    fa = (!va || lu_a) ? 2'b00 : ex_a ? 2'b01 :
         (hz.mem_we && hz.id_rs1 == hz.mem_rd) ? 2'b10 :
         (hz.wb_we && hz.id_rs1 == hz.wb_rd) ? 2'b11 : 2'b00;
    fb = (!vb || lu_b) ? 2'b00 : ex_b ? 2'b01 :
         (hz.mem_we && hz.id_rs2 == hz.mem_rd) ? 2'b10 :
         (hz.wb_we && hz.id_rs2 == hz.wb_rd) ? 2'b11 : 2'b00;
  end
  always_comb begin
    state_nxt = state;
    wait_nxt = wait_cnt;
    to_nxt = to_q;
    st_pc = 1'b0;
    st_if_id = 1'b0;
    st_id_ex = 1'b0;
    fl_if_id = 1'b0;
    fl_id_ex = 1'b0;
    fl_ex_mem = 1'b0;
    start = 1'b0;
    if (state == S_RUN) begin
      if (hz.ex_md_op) begin
        start = 1'b1;
        st_pc = 1'b1;
        st_if_id = 1'b1;
        st_id_ex = 1'b1;
        fl_ex_mem = 1'b1;
        wait_nxt = '0;
        state_nxt = S_MD_WAIT;
      end else if (hz.ex_redirect) begin
        fl_if_id = 1'b1;
        fl_id_ex = 1'b1;
      end else if (lu_a || lu_b) begin
        st_pc = 1'b1;
        st_if_id = 1'b1;
        fl_id_ex = 1'b1;
      end
    end else if (hz.md_done || wait_cnt == WW'(MD_TIMEOUT - 1)) begin
      state_nxt = S_RUN;
      to_nxt = to_q | ~hz.md_done;
    end else begin
      st_pc = 1'b1;
      st_if_id = 1'b1;
      st_id_ex = 1'b1;
      fl_ex_mem = 1'b1;
      wait_nxt = wait_cnt + WW'(1);
    end
  end
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state <= S_RUN;
      wait_cnt <= '0;
      to_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      wait_cnt <= wait_nxt;
      to_q <= to_nxt;
      cnt_q <= cnt_q + CNT_W'(st_pc & ~&cnt_q);
    end
  end
  assign hz.fwd_a = fa;
  assign hz.fwd_b = fb;
  assign hz.stall_pc = st_pc;
  assign hz.stall_if_id = st_if_id;
  assign hz.stall_id_ex = st_id_ex;
  assign hz.flush_if_id = fl_if_id;
  assign hz.flush_id_ex = fl_id_ex;
  assign hz.flush_ex_mem = fl_ex_mem;
  assign hz.md_start = start;
  assign hz.md_timeout = to_q;
  assign hz.stall_cnt = cnt_q;
endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb_ex_hazard_ctrl: two controllers (timeout 64 and 4) on shared stimulus, scoreboarded against a reference model
module tb_ex_hazard_ctrl;
  typedef struct {
    logic rst;
    logic [4:0] rs1, rs2, exr, memr, wbr;
    logic u1, u2, exwe, ld, memwe, wbwe, md, redir, done;
  } stim_t;
  typedef struct {
    logic [43:0] v;
    string tag;
  } exp_t;
  logic cpu_clk = 1'b0;
  logic cpu_rst = 1'b1;
  stim_t st;
  logic [43:0] act [2];
  exp_t q [2][$];
  exp_t me;
  int tos [2] = '{64, 4};
  bit m_wait [2];
  int m_age [2];
  bit m_to [2];
  longint m_cnt [2];
  int checks = 0;
  int failures = 0;
  always #5 cpu_clk = ~cpu_clk;
  for (genvar g = 0; g < 2; g++) begin : gi
    ex_hazard_ctrl_if #(.CNT_W(32)) hz();
    ex_hazard_ctrl #(.MD_TIMEOUT(g == 0 ? 64 : 4), .CNT_W(32)) dut (
      .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .hz(hz));
    assign hz.id_rs1 = st.rs1;
    assign hz.id_rs2 = st.rs2;
    assign hz.ex_rd = st.exr;
    assign hz.mem_rd = st.memr;
    assign hz.wb_rd = st.wbr;
    assign hz.id_use_rs1 = st.u1;
    assign hz.id_use_rs2 = st.u2;
    assign hz.ex_we = st.exwe;
    assign hz.ex_is_load = st.ld;
    assign hz.mem_we = st.memwe;
    assign hz.wb_we = st.wbwe;
    assign hz.ex_md_op = st.md;
    assign hz.ex_redirect = st.redir;
    assign hz.md_done = st.done;
    assign act[g] = {hz.fwd_a, hz.fwd_b, hz.stall_pc, hz.stall_if_id, hz.stall_id_ex,
                     hz.flush_if_id, hz.flush_id_ex, hz.flush_ex_mem, hz.md_start,
                     hz.md_timeout, hz.stall_cnt};
  end
  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b0;
    s.rs1 = '0; s.rs2 = '0; s.exr = '0; s.memr = '0; s.wbr = '0;
    s.u1 = 1'b0; s.u2 = 1'b0; s.exwe = 1'b0; s.ld = 1'b0; s.memwe = 1'b0;
    s.wbwe = 1'b0; s.md = 1'b0; s.redir = 1'b0; s.done = 1'b0;
    return s;
  endfunction
  function automatic logic [1:0] ref_fwd(input stim_t s, input logic u, input logic [4:0] rs);
    if (!u || rs == 5'd0) return 2'b00;
    if (s.exwe && s.exr == rs) return s.ld ? 2'b00 : 2'b01;
    if (s.memwe && s.memr == rs) return 2'b10;
    if (s.wbwe && s.wbr == rs) return 2'b11;
    return 2'b00;
  endfunction
  task automatic apply(input stim_t s, input string tag);
    exp_t e;
    logic lu;
    logic [6:0] c;
    @(negedge cpu_clk);
    st = s;
    cpu_rst = s.rst;
    lu = s.exwe && s.ld && s.exr != 5'd0 &&
         ((s.u1 && s.rs1 == s.exr) || (s.u2 && s.rs2 == s.exr));
    for (int i = 0; i < 2; i++) begin
      // {stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex, flush_ex_mem, md_start}
      if (!m_wait[i])
        c = s.md ? 7'b1110011 : s.redir ? 7'b0001100 : lu ? 7'b1100100 : 7'b0000000;
      else
        c = (s.done || m_age[i] == tos[i] - 1) ? 7'b0000000 : 7'b1110010;
      e.v = {ref_fwd(s, s.u1, s.rs1), ref_fwd(s, s.u2, s.rs2), c, m_to[i], m_cnt[i][31:0]};
      e.tag = tag;
      q[i].push_back(e);
      if (s.rst) begin
        m_wait[i] = 0; m_age[i] = 0; m_to[i] = 0; m_cnt[i] = 0;
      end else begin
        if (c[6] && m_cnt[i] < 64'h0000_0000_FFFF_FFFF) m_cnt[i]++;
        if (!m_wait[i]) begin
          if (s.md) begin m_wait[i] = 1; m_age[i] = 0; end
        end else if (s.done) m_wait[i] = 0;
        else if (m_age[i] == tos[i] - 1) begin m_wait[i] = 0; m_to[i] = 1; end
        else m_age[i]++;
      end
    end
  endtask
  task automatic chk(input int inst, input string tag, input string nm,
                     input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL inst%0d %s %s actual=%h required=%h", inst, tag, nm, a, x);
    end
  endtask
  initial forever begin
    @(negedge cpu_clk);
    #2;
    for (int i = 0; i < 2; i++)
      if (q[i].size() > 0) begin
        me = q[i].pop_front();
        chk(i, me.tag, "fwd", 32'(act[i][43:40]), 32'(me.v[43:40]));
        chk(i, me.tag, "ctl", 32'(act[i][39:32]), 32'(me.v[39:32]));
        chk(i, me.tag, "stall_cnt", act[i][31:0], me.v[31:0]);
      end
  end
  initial begin
    stim_t s;
    st = idle();
    cpu_rst = 1'b1;
    s = idle(); s.rst = 1'b1;
    apply(s, "reset"); apply(s, "reset");
    s = idle(); apply(s, "idle");
    s.rs1 = 5; s.u1 = 1; s.exr = 5; s.exwe = 1; s.memr = 5; s.memwe = 1;
    apply(s, "fwd_ex");
    s.exwe = 0; apply(s, "fwd_mem");
    s = idle(); s.rs2 = 0; s.u2 = 1; s.wbr = 0; s.wbwe = 1; s.rs1 = 3; s.u1 = 0; s.exr = 3; s.exwe = 1;
    apply(s, "fwd_zero");
    s = idle(); s.exwe = 1; s.ld = 1; s.exr = 7; s.rs2 = 7; s.u2 = 1;
    apply(s, "load_use");
    s = idle(); apply(s, "lu_release"); apply(s, "lu_cnt");
    s = idle(); s.exwe = 1; s.ld = 1; s.exr = 7; s.rs2 = 7; s.u2 = 1; s.redir = 1;
    apply(s, "lu_redirect");
    s = idle(); s.rst = 1; apply(s, "reset2");
    s = idle(); s.md = 1; apply(s, "md_start");
    s = idle(); repeat (4) apply(s, "md_wait");
    s.done = 1; apply(s, "md_done");
    s = idle(); apply(s, "md_after"); apply(s, "md_after");
    s.md = 1; apply(s, "to_start");
    s = idle(); repeat (6) apply(s, "to_wait");
    s.rst = 1; apply(s, "to_clear");
    s = idle(); s.md = 1; apply(s, "rw_start");
    s = idle(); apply(s, "rw_wait");
    s.rst = 1; apply(s, "rw_reset");
    s = idle(); s.done = 1; apply(s, "late_done");
    s = idle(); apply(s, "rw_idle");
    for (int n = 0; n < 400; n++) begin
      s.rst = ($urandom_range(99) == 0);
      s.rs1 = 5'($urandom_range(3)); s.rs2 = 5'($urandom_range(3));
      s.exr = 5'($urandom_range(3)); s.memr = 5'($urandom_range(3)); s.wbr = 5'($urandom_range(3));
      s.u1 = 1'($urandom_range(1)); s.u2 = 1'($urandom_range(1));
      s.exwe = 1'($urandom_range(1)); s.ld = 1'($urandom_range(1));
      s.memwe = 1'($urandom_range(1)); s.wbwe = 1'($urandom_range(1));
      s.md = ($urandom_range(9) == 0); s.redir = ($urandom_range(7) == 0);
      s.done = ($urandom_range(5) == 0);
      apply(s, "random");
    end
    s = idle(); apply(s, "drain"); apply(s, "drain");
    @(negedge cpu_clk);
    #3;
    for (int i = 0; i < 2; i++) chk(i, "end", "queue_left", 32'(q[i].size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
